// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instruction requests into 32-bit MIPS words
// and writes them to consecutive instruction-memory addresses.
//
// Handshake: a request transfers on a rising clock edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state and start,
// so a producer may hold in_valid and its fields steady until it sees in_ready.
//
// state_dbg encoding: 0 IDLE, 1 ENCODE, 2 WRITE, 3 DONE.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    input  logic                  in_last,
    output logic                  imem_write_enable,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_write_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  full,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_ADDI = 4'd10;
    localparam logic [3:0] OP_LW   = 4'd11;
    localparam logic [3:0] OP_SW   = 4'd12;
    localparam logic [3:0] OP_BEQ  = 4'd13;
    localparam logic [3:0] OP_J    = 4'd14;

    localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] TOP     = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

    state_t state, state_next;

    logic [3:0]            op_q;
    logic [4:0]            rs_q, rt_q, rd_q, shamt_q;
    logic [15:0]           imm_q;
    logic [25:0]           target_q;
    logic                  last_q;
    logic [31:0]           word_q;
    logic [31:0]           enc_word;
    logic [ADDR_WIDTH-1:0] ptr;

    // Outputs decoded from state; start pre-empts both acceptance and the write.
    assign in_ready          = (state == S_IDLE) & ~start;
    assign imem_write_enable = (state == S_WRITE) & ~start;
    assign imem_addr         = ptr;
    assign imem_write_data   = word_q;
    assign state_dbg         = state;

    // Encode the captured fields; fields an op does not use are forced to zero.
    always_comb begin
        enc_word = 32'h0000_003F;
        case (op_q)
            OP_SLL:  enc_word = {6'b000000, 5'd0, rt_q, rd_q, shamt_q, 6'b000000};
            OP_SRL:  enc_word = {6'b000000, 5'd0, rt_q, rd_q, shamt_q, 6'b000010};
            OP_MULT: enc_word = {6'b000000, rs_q, rt_q, 5'd0, 5'd0, 6'b011000};
            OP_ADD:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100000};
            OP_SUB:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100010};
            OP_AND:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100100};
            OP_OR:   enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100101};
            OP_XOR:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100110};
            OP_NOR:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b100111};
            OP_SLT:  enc_word = {6'b000000, rs_q, rt_q, rd_q, 5'd0, 6'b101010};
            OP_ADDI: enc_word = {6'b001000, rs_q, rt_q, imm_q};
            OP_LW:   enc_word = {6'b100011, rs_q, rt_q, imm_q};
            OP_SW:   enc_word = {6'b101011, rs_q, rt_q, imm_q};
            OP_BEQ:  enc_word = {6'b000100, rs_q, rt_q, imm_q};
            OP_J:    enc_word = {6'b000010, target_q};
            default: enc_word = 32'h0000_003F;
        endcase
    end

    // Next-state logic; start always returns to IDLE.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (in_valid) state_next = S_ENCODE;
                S_ENCODE: state_next = S_WRITE;
                S_WRITE:  state_next = ((ptr == TOP) || last_q) ? S_DONE : S_IDLE;
                S_DONE:   state_next = S_DONE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Request capture, word register, write pointer and status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= 4'd0;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            rd_q     <= 5'd0;
            shamt_q  <= 5'd0;
            imm_q    <= 16'd0;
            target_q <= 26'd0;
            last_q   <= 1'b0;
            word_q   <= 32'd0;
            ptr      <= BASE;
            count    <= '0;
            done     <= 1'b0;
            full     <= 1'b0;
        end else if (start) begin
            ptr   <= BASE;
            count <= '0;
            done  <= 1'b0;
            full  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        rs_q     <= in_rs;
                        rt_q     <= in_rt;
                        rd_q     <= in_rd;
                        shamt_q  <= in_shamt;
                        imm_q    <= in_imm;
                        target_q <= in_target;
                        last_q   <= in_last;
                    end
                end
                S_ENCODE: word_q <= enc_word;
                S_WRITE: begin
                    count <= count + CNT_ONE;
                    if (ptr == TOP) begin
                        // The top address is terminal: the pointer never wraps.
                        full <= 1'b1;
                        done <= 1'b1;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                        if (last_q) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: one full-size instance and one ADDR_WIDTH=2
// instance for the fill case, checked through expected-write queues.
module tb_instr_encoder;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_ENCODE = 2'd1, ST_WRITE = 2'd2, ST_DONE = 2'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0, in_valid_b = 1'b0;
    logic        in_ready, in_ready_b;
    logic [3:0]  in_op = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic        in_last = 1'b0;

    logic        we_a, we_b;
    logic [7:0]  addr_a;
    logic [1:0]  addr_b;
    logic [31:0] data_a, data_b;
    logic [8:0]  count_a;
    logic [2:0]  count_b;
    logic        done_a, done_b, full_a, full_b;
    logic [1:0]  st_a, st_b;

    logic [39:0] exp_q[$];
    logic [33:0] exp_b_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int writes_a = 0;

    instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_write_enable(we_a), .imem_addr(addr_a), .imem_write_data(data_a),
        .count(count_a), .done(done_a), .full(full_a), .state_dbg(st_a)
    );

    instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_write_enable(we_b), .imem_addr(addr_b), .imem_write_data(data_b),
        .count(count_b), .done(done_b), .full(full_b), .state_dbg(st_b)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the head of its queue.
    always @(negedge clock) begin
        if (!reset && we_a) begin
            writes_a++;
            if (exp_q.size() == 0) check("unexpected_write_a", {addr_a, data_a}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("write_a", {addr_a, data_a}, exp_q.pop_front());
        end
        if (!reset && we_b) begin
            if (exp_b_q.size() == 0) check("unexpected_write_b", {addr_b, data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
            else check("write_b", {addr_b, data_b}, exp_b_q.pop_front());
        end
    end

    // Driver: present a request, wait (bounded) for the handshake, queue the expectation.
    task automatic send(input bit to_b, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt, input bit last, input bit push,
                        input logic [7:0] addr, input logic [31:0] word);
        int k;
        @(negedge clock);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_last = last;
        if (to_b) in_valid_b = 1'b1; else in_valid = 1'b1;
        k = 0;
        while (!(to_b ? in_ready_b : in_ready) && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!(to_b ? in_ready_b : in_ready)) begin
            check("handshake_timeout", 64'd0, 64'd1);
        end else begin
            if (push) begin
                if (to_b) exp_b_q.push_back({addr[1:0], word});
                else      exp_q.push_back({addr, word});
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        in_valid_b = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_state(input bit b, input logic [1:0] s);
        int k = 0;
        @(negedge clock);
        while ((b ? st_b : st_a) != s && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("wait_state", {62'd0, (b ? st_b : st_a)}, {62'd0, s});
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        #1 check("ready_low_during_start", {63'd0, in_ready}, 64'd0);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Sweep table: op, rs, rt, rd, shamt, imm, target, expected word.
    logic [3:0]  sw_op [14] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd11, 4'd13, 4'd14, 4'd15};
    logic [4:0]  sw_rs [14] = '{5'd7, 5'd7, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd29, 5'd29, 5'd4, 5'd3, 5'd9};
    logic [4:0]  sw_rt [14] = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd8, 5'd8, 5'd5, 5'd6, 5'd9};
    logic [4:0]  sw_rd [14] = '{5'd2, 5'd2, 5'd9, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd17, 5'd17, 5'd1, 5'd7, 5'd9};
    logic [4:0]  sw_sh [14] = '{5'd4, 5'd4, 5'd3, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd9, 5'd9, 5'd2, 5'd1, 5'd9};
    logic [15:0] sw_imm[14] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234,
                                16'h1234, 16'h1234, 16'h0004, 16'h0004, 16'hFFFE, 16'h5555, 16'h9999};
    logic [25:0] sw_tgt[14] = '{26'h3FF, 26'h3FF, 26'h3FF, 26'h3FF, 26'h3FF, 26'h3FF, 26'h3FF,
                                26'h3FF, 26'h3FF, 26'h3FF, 26'h3FF, 26'h3FF, 26'h10, 26'h3FF};
    logic [31:0] sw_exp[14] = '{32'h00011100, 32'h00011102, 32'h00220018, 32'h00221822, 32'h00221824,
                                32'h00221825, 32'h00221826, 32'h00221827, 32'h0022182A, 32'hAFA80004,
                                32'h8FA80004, 32'h1085FFFE, 32'h08000010, 32'h0000003F};

    initial begin
        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_we", {63'd0, we_a}, 64'd0);
        check("rst_count", {55'd0, count_a}, 64'd0);
        check("rst_done", {63'd0, done_a}, 64'd0);
        check("rst_full", {63'd0, full_a}, 64'd0);
        check("rst_data", {32'd0, data_a}, 64'd0);
        reset = 1'b0;
        #1 check("rst_ready", {63'd0, in_ready}, 64'd1);
        check("rst_addr", {56'd0, addr_a}, 64'd0);

        // ADD then ADDI with in_last.
        send(0, 4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0, 1, 8'd0, 32'h00221820);
        send(0, 4'd10, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1, 1, 8'd1, 32'h2005FFFF);
        wait_state(0, ST_DONE);
        check("prog_count", {55'd0, count_a}, 64'd2);
        check("prog_done", {63'd0, done_a}, 64'd1);
        check("prog_full", {63'd0, full_a}, 64'd0);
        check("prog_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("done_no_accept", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;

        // Encoding sweep.
        pulse_start();
        check("start_count", {55'd0, count_a}, 64'd0);
        check("start_done", {63'd0, done_a}, 64'd0);
        for (int i = 0; i < 14; i++)
            send(0, sw_op[i], sw_rs[i], sw_rt[i], sw_rd[i], sw_sh[i], sw_imm[i], sw_tgt[i],
                 (i == 13), 1, 8'(i), sw_exp[i]);
        wait_state(0, ST_DONE);
        check("sweep_count", {55'd0, count_a}, 64'd14);
        check("sweep_done", {63'd0, done_a}, 64'd1);

        // start during WRITE of the second word.
        pulse_start();
        send(0, 4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0, 1, 8'd0, 32'h00221820);
        wait_state(0, ST_IDLE);
        send(0, 4'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0, 0, 8'd0, 32'h0);
        wait_state(0, ST_WRITE);
        begin
            int w0;
            w0 = writes_a;
            start = 1'b1;
            #1 check("start_we_suppressed", {63'd0, we_a}, 64'd0);
            @(posedge clock);
            #1 start = 1'b0;
            check("start_state_idle", {62'd0, st_a}, {62'd0, ST_IDLE});
            check("start_count_zero", {55'd0, count_a}, 64'd0);
            @(negedge clock);
            check("start_no_write", 64'(writes_a), 64'(w0));
        end
        send(0, 4'd6, 5'd1, 5'd2, 5'd7, 5'd0, 16'h0, 26'h0, 0, 1, 8'd0, 32'h00223825);
        wait_state(0, ST_IDLE);
        check("restart_count", {55'd0, count_a}, 64'd1);

        // Asynchronous reset mid-ENCODE.
        send(0, 4'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0, 0, 8'd0, 32'h0);
        check("in_encode", {62'd0, st_a}, {62'd0, ST_ENCODE});
        #2 reset = 1'b1;
        #1 check("arst_data", {32'd0, data_a}, 64'd0);
        check("arst_addr", {56'd0, addr_a}, 64'd0);
        check("arst_count", {55'd0, count_a}, 64'd0);
        check("arst_we", {63'd0, we_a}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("arst_ready", {63'd0, in_ready}, 64'd1);
        check("arst_state", {62'd0, st_a}, {62'd0, ST_IDLE});

        // start and in_valid together in IDLE.
        @(negedge clock);
        in_op = 4'd5; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_shamt = 5'd0;
        start = 1'b1;
        in_valid = 1'b1;
        #1 check("start_vs_valid_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clock);
        #1 check("start_vs_valid_idle", {62'd0, st_a}, {62'd0, ST_IDLE});
        start = 1'b0;
        in_valid = 1'b0;
        send(0, 4'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 0, 1, 8'd0, 32'h00221824);
        wait_state(0, ST_IDLE);
        check("retry_count", {55'd0, count_a}, 64'd1);

        // Fill the 4-word instance.
        for (int i = 0; i < 4; i++)
            send(1, 4'd3, 5'd1, 5'd2, 5'(i + 1), 5'd0, 16'h0, 26'h0, 0, 1, 8'(i),
                 32'h00220020 | (32'(i + 1) << 11));
        wait_state(1, ST_DONE);
        check("fill_full", {63'd0, full_b}, 64'd1);
        check("fill_done", {63'd0, done_b}, 64'd1);
        check("fill_count", {61'd0, count_b}, 64'd4);
        in_valid_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("fill_no_accept", {63'd0, in_ready_b}, 64'd0);
        end
        in_valid_b = 1'b0;

        repeat (3) @(negedge clock);
        check("queue_a_drained", 64'(exp_q.size()), 64'd0);
        check("queue_b_drained", 64'(exp_b_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
